// File: rtl/y_window_sched.sv
// Sequencer for the 5-row vertical filter window: line-buffer write select, filter hsel/validin, end-of-frame drain and result position tags.
// Optional build macro YWIN_SCHED_STATS_EN adds frame and error counters.
module y_window_sched #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int COL_W  = 10,
  parameter int ROW_W  = 9
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_sof,
  input  logic             i_pix_valid,
  output logic [4:0]       o_wr_en,
  output logic [COL_W-1:0] o_col,
  output logic [2:0]       o_hsel,
  output logic             o_win_valid,
  output logic             o_res_valid,
  output logic [COL_W-1:0] o_res_col,
  output logic [ROW_W-1:0] o_res_row,
  output logic             o_res_eol,
  output logic             o_res_eof,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic             o_err
`ifdef YWIN_SCHED_STATS_EN
  ,
  output logic [15:0]      o_frame_cnt,
  output logic [7:0]       o_err_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN} state_t;

  typedef struct packed {
    logic             vld;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             eol;
    logic             eof;
  } tag_t;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

  state_t           r_state, w_state_nxt;
  logic [COL_W-1:0] r_col, w_col, w_col_nxt;
  logic [ROW_W-1:0] r_row, w_row, w_row_nxt;
  logic [2:0]       r_wp, w_wp, w_wp_nxt;
  logic [2:0]       r_dcnt, w_dcnt_nxt;
  logic             r_err;
  tag_t             r_tag [5];
  tag_t             w_tag_in;
  logic             w_live, w_run_or_fill, w_restart, w_accept, w_drop, w_home;
  logic             w_eol, w_win_valid, w_frame_done;

  // A restart (sof mid-frame) or a fresh start forces the pixel position to (0,0), wp 0.
  always_comb begin
    w_live        = ~i_reset;
    w_run_or_fill = (r_state == S_FILL) || (r_state == S_RUN);
    w_restart     = w_live & i_sof & i_pix_valid & w_run_or_fill;
    w_accept      = w_live & i_pix_valid & (w_run_or_fill | ((r_state == S_IDLE) & i_sof));
    w_drop        = w_live & i_pix_valid & (r_state == S_DRAIN);
    w_home        = (r_state == S_IDLE) | w_restart;
    w_col         = w_home ? '0 : r_col;
    w_row         = w_home ? '0 : r_row;
    w_wp          = w_home ? 3'd0 : r_wp;
    w_eol         = (w_col == LAST_COL);
    w_win_valid   = w_live & (((r_state == S_RUN) & i_pix_valid & ~i_sof) | (r_state == S_DRAIN));
    w_frame_done  = w_win_valid & (r_state == S_DRAIN) & (r_dcnt == 3'd4);
    w_tag_in      = '0;
    if (r_state == S_RUN) begin
      w_tag_in.vld = 1'b1;
      w_tag_in.col = r_col;
      w_tag_in.row = r_row - ROW_W'(2);
      w_tag_in.eol = w_eol;
      w_tag_in.eof = w_eol & (r_row == LAST_ROW);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_wp_nxt    = r_wp;
    w_dcnt_nxt  = r_dcnt;
    if (w_accept) begin
      w_state_nxt = w_home ? S_FILL : r_state;
      if (w_eol) begin
        w_col_nxt = '0;
        w_row_nxt = w_row + ROW_W'(1);
        w_wp_nxt  = (w_wp == 3'd4) ? 3'd0 : w_wp + 3'd1;
        if (w_row == LAST_ROW) begin
          w_state_nxt = S_DRAIN;
          w_row_nxt   = '0;
          w_dcnt_nxt  = '0;
        end else if (w_row == ROW_W'(3)) begin
          w_state_nxt = S_RUN;
        end
      end else begin
        w_col_nxt = w_col + COL_W'(1);
        w_row_nxt = w_row;
        w_wp_nxt  = w_wp;
      end
    end else if (r_state == S_DRAIN) begin
      w_dcnt_nxt = r_dcnt + 3'd1;
      if (r_dcnt == 3'd4) begin
        w_state_nxt = S_IDLE;
        w_dcnt_nxt  = '0;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_wp    <= '0;
      r_dcnt  <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < 5; i++) r_tag[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_wp    <= w_wp_nxt;
      r_dcnt  <= w_dcnt_nxt;
      if (w_restart || w_drop) r_err <= 1'b1;
      // Tags track the filter pipeline, so they only move when the filter does.
      if (w_win_valid) begin
        r_tag[0] <= w_tag_in;
        for (int i = 1; i < 5; i++) r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign o_wr_en      = w_accept ? (5'b00001 << w_wp) : 5'b00000;
  assign o_col        = w_live ? w_col : '0;
  assign o_hsel       = (w_live && (r_state != S_IDLE)) ? ((w_wp == 3'd4) ? 3'd0 : w_wp + 3'd1) : 3'd0;
  assign o_win_valid  = w_win_valid;
  assign o_res_valid  = w_win_valid & r_tag[4].vld;
  assign o_res_col    = r_tag[4].col;
  assign o_res_row    = r_tag[4].row;
  assign o_res_eol    = r_tag[4].eol;
  assign o_res_eof    = r_tag[4].eof;
  assign o_busy       = (r_state != S_IDLE);
  assign o_frame_done = w_frame_done;
  assign o_err        = r_err;

`ifdef YWIN_SCHED_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [7:0]  r_err_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
      if ((w_restart || w_drop) && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
  assign o_err_cnt   = r_err_cnt;
`endif

endmodule

// File: tb/tb_y_window_sched.sv
// Bench for y_window_sched on an 8x6 frame: reset/idle vector table, then frame-level sequences with a result scoreboard.
module tb_y_window_sched;
  localparam int W    = 8;
  localparam int H    = 6;
  localparam int CW   = 10;
  localparam int RW   = 9;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sof = 1'b0;
  logic          pv  = 1'b0;
  logic [4:0]    wr_en;
  logic [CW-1:0] col;
  logic [2:0]    hsel;
  logic          win_valid, res_valid;
  logic [CW-1:0] res_col;
  logic [RW-1:0] res_row;
  logic          res_eol, res_eof, busy, frame_done, err;
`ifdef YWIN_SCHED_STATS_EN
  logic [15:0]   frame_cnt;
  logic [7:0]    err_cnt;
`endif

  y_window_sched #(.WIDTH(W), .HEIGHT(H), .COL_W(CW), .ROW_W(RW)) dut (
    .i_clock(clk), .i_reset(rst), .i_sof(sof), .i_pix_valid(pv),
    .o_wr_en(wr_en), .o_col(col), .o_hsel(hsel), .o_win_valid(win_valid),
    .o_res_valid(res_valid), .o_res_col(res_col), .o_res_row(res_row),
    .o_res_eol(res_eol), .o_res_eof(res_eof), .o_busy(busy),
    .o_frame_done(frame_done), .o_err(err)
`ifdef YWIN_SCHED_STATS_EN
    , .o_frame_cnt(frame_cnt), .o_err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          eol;
    logic          eof;
  } res_t;

  typedef struct {
    logic          rst, sof, pv;
    logic [4:0]    wr;
    logic [CW-1:0] col;
    logic [2:0]    hsel;
    logic          wv, busy, err;
  } vec_t;

  res_t exp_q[$];
  res_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   win_cnt = 0;
  int   res_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Result monitor: every res_valid must match the oldest expected window.
  always @(negedge clk) begin
    if (win_valid === 1'b1) win_cnt++;
    if (res_valid === 1'b1) begin
      res_cnt++;
      chk("res_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk($sformatf("res_col(%0d,%0d)", mon_e.row, mon_e.col), res_col, mon_e.col);
        chk($sformatf("res_row(%0d,%0d)", mon_e.row, mon_e.col), res_row, mon_e.row);
        chk($sformatf("res_eol(%0d,%0d)", mon_e.row, mon_e.col), res_eol, mon_e.eol);
        chk($sformatf("res_eof(%0d,%0d)", mon_e.row, mon_e.col), res_eof, mon_e.eof);
      end
    end
  end

  task automatic cyc_in(input logic s, input logic p);
    sof = s;
    pv  = p;
    @(negedge clk);
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sof = 1'b1; pv = 1'b1;
    cyc_end();
    @(negedge clk);
    chk("rst_outs_a", {wr_en, col, hsel, win_valid, res_valid, busy, frame_done, err}, 0);
    chk("rst_outs_b", {res_col, res_row, res_eol, res_eof}, 0);
`ifdef YWIN_SCHED_STATS_EN
    chk("rst_stats", {frame_cnt, err_cnt}, 0);
`endif
    cyc_end();
    rst = 1'b0; sof = 1'b0; pv = 1'b0;
    exp_q.delete();
    win_cnt = 0;
    res_cnt = 0;
  endtask

  // Pixels first..last of a frame (linear index); sof rides on index 0.
  task automatic send_pixels(input int first, input int last, input bit gap);
    res_t e;
    for (int p = first; p <= last; p++) begin
      int r, c;
      r = p / W;
      c = p % W;
      if (gap && p != first) begin
        cyc_in(1'b0, 1'b0);
        chk("gap_wr_en", wr_en, 0);
        chk("gap_win_valid", win_valid, 0);
        cyc_end();
      end
      cyc_in(p == 0, 1'b1);
      chk($sformatf("wr_en(%0d,%0d)", r, c), wr_en, 64'(1) << (r % 5));
      chk($sformatf("col(%0d,%0d)", r, c), col, c);
      chk($sformatf("win_valid(%0d,%0d)", r, c), win_valid, r >= 4);
      if (r >= 4) begin
        chk($sformatf("hsel(%0d,%0d)", r, c), hsel, ((r % 5) + 1) % 5);
        e.col = CW'(c);
        e.row = RW'(r - 2);
        e.eol = (c == W - 1);
        e.eof = (c == W - 1) && (r == H - 1);
        exp_q.push_back(e);
      end
      cyc_end();
    end
  endtask

  task automatic drain(input logic p);
    for (int d = 0; d < 5; d++) begin
      cyc_in(1'b0, p);
      chk($sformatf("drain_win_valid%0d", d), win_valid, 1);
      chk($sformatf("drain_wr_en%0d", d), wr_en, 0);
      chk($sformatf("drain_frame_done%0d", d), frame_done, d == 4);
      chk($sformatf("drain_busy%0d", d), busy, 1);
      cyc_end();
    end
  endtask

  task automatic idle_check(input logic p);
    cyc_in(1'b0, p);
    chk("idle_busy", busy, 0);
    chk("idle_win_valid", win_valid, 0);
    chk("idle_wr_en", wr_en, 0);
    chk("idle_frame_done", frame_done, 0);
    cyc_end();
  endtask

  task automatic frame_counts(input int exp_win, input int exp_res);
    chk("win_count", win_cnt, exp_win);
    chk("res_count", res_cnt, exp_res);
    chk("results_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    //            rst   sof   pv    wr_en     col    hsel  wv    busy  err
    vecs[0] = '{1'b1, 1'b1, 1'b1, 5'b00000, 10'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 5'b00000, 10'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 5'b00001, 10'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 5'b00001, 10'd1, 3'd1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 5'b00000, 10'd2, 3'd1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 5'b00001, 10'd2, 3'd1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 5'b00000, 10'd3, 3'd1, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 7; i++) begin
      rst = vecs[i].rst;
      cyc_in(vecs[i].sof, vecs[i].pv);
      chk($sformatf("vec%0d_wr_en", i), wr_en, vecs[i].wr);
      chk($sformatf("vec%0d_col", i), col, vecs[i].col);
      chk($sformatf("vec%0d_hsel", i), hsel, vecs[i].hsel);
      chk($sformatf("vec%0d_win_valid", i), win_valid, vecs[i].wv);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("vec%0d_err", i), err, vecs[i].err);
      chk($sformatf("vec%0d_res_quiet", i), {res_valid, frame_done, res_col, res_row, res_eol, res_eof}, 0);
      cyc_end();
    end

    // Continuous frame.
    do_reset();
    send_pixels(0, NPIX - 1, 1'b0);
    drain(1'b0);
    idle_check(1'b0);
    frame_counts(21, 16);

    // Same frame with pix_valid toggling.
    do_reset();
    send_pixels(0, NPIX - 1, 1'b1);
    drain(1'b0);
    idle_check(1'b0);
    frame_counts(21, 16);

    // sof at row 2 col 3 restarts the frame and flags an error.
    do_reset();
    send_pixels(0, 2 * W + 2, 1'b0);
    cyc_in(1'b0, 1'b0);
    chk("restart_err_before", err, 0);
    cyc_end();
    send_pixels(0, 0, 1'b0);
    cyc_in(1'b0, 1'b0);
    chk("restart_err_after", err, 1);
    chk("restart_busy", busy, 1);
    cyc_end();
    send_pixels(1, NPIX - 1, 1'b0);
    drain(1'b0);
    idle_check(1'b0);
    frame_counts(21, 16);
    chk("restart_err_sticky", err, 1);

    // pix_valid held during drain: dropped, error, drain length unchanged.
    do_reset();
    cyc_in(1'b0, 1'b0);
    chk("err_cleared_by_reset", err, 0);
    cyc_end();
    send_pixels(0, NPIX - 1, 1'b0);
    drain(1'b1);
    idle_check(1'b1);
    frame_counts(21, 16);
    chk("drain_pix_err", err, 1);
`ifdef YWIN_SCHED_STATS_EN
    chk("drain_err_cnt", err_cnt, 5);
`endif

    // Two back-to-back frames.
    do_reset();
    send_pixels(0, NPIX - 1, 1'b0);
    drain(1'b0);
    chk("b2b_first_frame_results", res_cnt, 16);
    send_pixels(0, NPIX - 1, 1'b0);
    drain(1'b0);
    idle_check(1'b0);
    frame_counts(42, 32);
    chk("b2b_err", err, 0);
`ifdef YWIN_SCHED_STATS_EN
    chk("b2b_frame_cnt", frame_cnt, 2);
    chk("b2b_err_cnt", err_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/y_window_sched.md
# y_window_sched

Sequencer for the 5-row vertical filter window and its five line buffers. Tracks column/row position of the incoming pixel stream, rotates the line-buffer write select, drives the filter's `hsel` and `validin`, and drains the filter pipeline at end of frame. Emits per-result position tags aligned with the filter's `dout`, so downstream blocks never count the filter's latency themselves.

## Interface
- `WIDTH`, 640, pixels per line
- `HEIGHT`, 480, lines per frame (≥5)
- `COL_W`, 10, column counter/address width
- `ROW_W`, 9, row counter width
- `clock` in 1 — single clock domain
- `reset` in 1 — synchronous, active-high
- `sof` in 1 — start of frame; qualified by `pix_valid`, marks pixel (row 0, col 0)
- `pix_valid` in 1 — input pixel present this cycle
- `wr_en` out 5 — one-hot line-buffer write enable; equals `pix_valid` gated onto buffer `wp`
- `col` out COL_W — line-buffer read/write address (current column)
- `hsel` out 3 — coefficient rotation to the filter
- `win_valid` out 1 — filter `validin`; also the tag-pipeline advance
- `res_valid` out 1 — filter `dout` holds a real result this cycle
- `res_col` out COL_W, `res_row` out ROW_W — result position (row = window centre row)
- `res_eol`, `res_eof` out 1 — result is last of line / last of frame
- `busy` out 1 — state ≠ IDLE
- `frame_done` out 1 — one-cycle pulse on final drain cycle
- `err` out 1 — sticky protocol error; cleared only by reset

## Operation
- States: IDLE, FILL, RUN, DRAIN.
- IDLE: `sof & pix_valid` → accept pixel as (0,0); `wp`←0; → FILL. `sof` without `pix_valid` is ignored.
- Counters: `col` increments per accepted pixel and wraps at WIDTH-1; `row` increments on wrap; `wp` increments mod 5 on wrap.
- FILL (rows 0–3): write only; `win_valid`=0. At end of row 3 → RUN.
- RUN (rows 4..HEIGHT-1): `win_valid`=`pix_valid`. Live pixel is bypassed into the window by the datapath.
- `hsel` = (`wp`+1) mod 5 in every state (IDLE: 0). This places the centre tap on buffer (`wp`+3) mod 5, i.e., row `row`-2.
- On the last pixel of row HEIGHT-1 → DRAIN with a 3-bit counter.
- DRAIN: `win_valid`=1 for exactly 5 cycles of dummy windows; `wr_en`=0; `frame_done` is pulsed on the 5th cycle; then → IDLE.
- Tag pipeline: 5 stages {real, col, row, eol, eof}, shifted only when `win_valid`=1. Stage 0 is loaded with real=1 in RUN and real=0 in DRAIN.
  - `res_*` are driven from stage 4.
  - `res_valid` = `win_valid` & stage4.real.
- `sof & pix_valid` in FILL/RUN: set `err`, restart as from IDLE (pixel becomes (0,0), → FILL). Tags already in flight are kept.
- `pix_valid` in DRAIN: set `err`, pixel dropped. A `sof` in DRAIN is also dropped.
- `res_row` = `row`-2 at entry; `res_eol` = (`col`==WIDTH-1); `res_eof` = `res_eol` & (`row`==HEIGHT-1).

## Timing
- Reset: state IDLE, `col`/`row`/`wp`/drain counter 0, all tag real bits 0, `err`=0.
  - All outputs read 0 in the cycle after reset, including `hsel`=0.
- `wr_en`, `col`, `hsel`, `win_valid` are combinational from the registered state and `pix_valid` in the same cycle as the pixel.
- `res_*` and `busy` are registered-state derived. `frame_done` and `res_valid` are qualified by the current `win_valid`.
- Latency: a window entered on advance *i* appears with `res_valid` on advance *i*+5. This matches the 5-register filter pipeline.
- Gaps in `pix_valid` stall both filter and tags. No result is lost or duplicated.
- A `reset` mid-frame discards all state.
  - The filter's saturated warm-up counter is also reset by the shared `reset`.

## Configuration
- `YWIN_SCHED_STATS_EN` defined: adds `frame_cnt` out 16 (frames completed, wraps at 65535→0) and `err_cnt` out 8 (error events, saturating at 255). Both are reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

## Test plan
- Reset with `sof`=`pix_valid`=1 held → every output is 0 during reset; first pixel accepted at row 0, col 0 on the cycle after reset deasserts.
- WIDTH=8, HEIGHT=6, continuous frame:
  - `wr_en` row sequence 00001,00010,00100,01000,10000,00001.
  - First `win_valid` at pixel 32; `hsel`=0 on row 4, 1 on row 5.
  - 16 `res_valid` total with `res_row` 2,3; `res_eof` only on (3,7); `frame_done` 5 cycles after the last pixel.
- Same frame with `pix_valid` toggling every other cycle → identical `res_*` sequence; `win_valid` count 21.
- `sof` at row 2 col 3 → `err`=1; `wp` restarts at 0; `wr_en`=00001.
- `pix_valid` during DRAIN → `err`=1; `wr_en`=0; drain length stays 5.
- Two back-to-back frames with `YWIN_SCHED_STATS_EN` → `frame_cnt`=2; first result of frame 2 has `res_row`=2, `res_col`=0.
